seq_encoder: RTL and testbench

SEQ_ENCODER -- requirements
Module: seq_encoder

---
 rtl/seq_encoder.sv | 113 +++++++++++
 tb/tb_seq_encoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_encoder.sv
// Sticky request capture with a one-index-per-cycle valid/ack encoder.
// Define SEQ_ENCODER_RR_EN for round-robin priority; the default is fixed priority.
module seq_encoder #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] d,
    input  logic         ack,
    output logic [W-1:0] a,
    output logic         valid,
    output logic [N-1:0] pend
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t       state;
    state_t       state_nx;
    logic [N-1:0] clr_mask;
    logic [N-1:0] req_nx;
    logic [N-1:0] sel_src;
    logic [W-1:0] start_idx;
    logic [W-1:0] sel_idx;
    logic         sel_any;
    logic         load_a;
    logic         done;
    int           j;
    logic [W-1:0] jj;

    function automatic logic [W-1:0] prev_idx(input logic [W-1:0] k);
        return (k == '0) ? W'(N - 1) : k - W'(1);
    endfunction

    assign done = (state == HOLD) && ack;

`ifdef SEQ_ENCODER_RR_EN
    logic [W-1:0] ptr;

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= W'(N - 1);
        else if (done)
            ptr <= prev_idx(a);
    end

    // After an ack the search resumes just below the index that was served.
    assign start_idx = (state == HOLD) ? prev_idx(a) : ptr;
`else
    assign start_idx = W'(N - 1);
`endif

    // A set from d in the same cycle wins over the ack clear.
    always_comb begin
        clr_mask = '0;
        if (done)
            clr_mask = N'(1) << a;
        req_nx = (pend & ~clr_mask) | (en ? d : '0);
    end

    assign sel_src = (state == HOLD) ? req_nx : pend;

    always_comb begin
        sel_any = 1'b0;
        sel_idx = '0;
        j       = 0;
        jj      = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(start_idx) - k;
            if (j < 0)
                j = j + N;
            jj = W'(j);
            if (!sel_any && sel_src[jj]) begin
                sel_any = 1'b1;
                sel_idx = jj;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (|pend) state_nx = HOLD;
            HOLD: if (ack && !sel_any) state_nx = IDLE;
        endcase
    end

    always_comb begin
        valid = (state == HOLD);
    end

    assign load_a = ((state == IDLE) && (|pend)) || (done && sel_any);

    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
            a    <= '0;
        end else begin
            pend <= req_nx;
            if (load_a)
                a <= sel_idx;
        end
    end

endmodule

// File: tb/tb_seq_encoder.sv
// Self-checking bench for seq_encoder: directed scenarios plus randomized
// traffic compared against a queue-free behavioural model.
module tb_seq_encoder;

    localparam int N = 16;
    localparam int W = 4;
`ifdef SEQ_ENCODER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         en    = 1'b0;
    logic         ack   = 1'b0;
    logic [N-1:0] d     = '0;
    logic [W-1:0] a;
    logic         valid;
    logic [N-1:0] pend;

    int checks = 0;
    int passed = 0;

    logic [N-1:0] m_pend = '0;
    bit           m_busy = 1'b0;
    int           m_idx  = 0;
    int           m_ptr  = N - 1;

    seq_encoder #(.N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (d),
        .ack   (ack),
        .a     (a),
        .valid (valid),
        .pend  (pend)
    );

    always #5 clk = ~clk;

    // Scan downward from start, wrapping, for the first set request.
    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            int jx;
            jx = (start - k + N) % N;
            if (v[4'(jx)])
                return jx;
        end
        return -1;
    endfunction

    task automatic cycle();
        logic [N-1:0] nxt;
        int           s;
        @(posedge clk);
        if (reset) begin
            m_pend = '0;
            m_busy = 1'b0;
            m_idx  = 0;
            m_ptr  = N - 1;
        end else begin
            nxt = m_pend | (en ? d : '0);
            if (m_busy && ack) begin
                if (!(en && d[4'(m_idx)]))
                    nxt[4'(m_idx)] = 1'b0;
                m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
                s = pick(nxt, RR ? m_ptr : N - 1);
                if (s < 0)
                    m_busy = 1'b0;
                else
                    m_idx = s;
            end else if (!m_busy && m_pend != 0) begin
                m_idx  = pick(m_pend, RR ? m_ptr : N - 1);
                m_busy = 1'b1;
            end
            m_pend = nxt;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; d = '0; ack = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; d = '1; ack = 1'b1;
        cycle();
        cycle();
        checks++;
        if ({valid, a, pend} !== {1'b0, 4'd0, 16'h0000})
            $display("FAIL reset: valid=%b a=%0d pend=%h want 0 0 0000",
                     valid, a, pend);
        else passed++;
        reset = 1'b0; en = 1'b0; d = '0; ack = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        d = 16'h0400; en = 1'b1;
        cycle();
        d = '0; en = 1'b0;
        checks++;
        if (valid !== 1'b0)
            $display("FAIL single_latency: valid=%b want 0", valid);
        else passed++;
        cycle();
        checks++;
        if ({valid, a} !== {1'b1, 4'd10})
            $display("FAIL single_sel: valid=%b a=%0d want 1 10", valid, a);
        else passed++;
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        checks++;
        if ({valid, pend} !== {1'b0, 16'h0000})
            $display("FAIL single_ack: valid=%b pend=%h want 0 0000",
                     valid, pend);
        else passed++;
    endtask

    task automatic test_priority();
        do_reset();
        d = 16'h8001; en = 1'b1;
        cycle();
        d = '0; en = 1'b0; ack = 1'b1;
        cycle();
        checks++;
        if ({valid, a} !== {1'b1, 4'd15})
            $display("FAIL prio_first: valid=%b a=%0d want 1 15", valid, a);
        else passed++;
        cycle();
        checks++;
        if ({valid, a} !== {1'b1, 4'd0})
            $display("FAIL prio_b2b: valid=%b a=%0d want 1 0", valid, a);
        else passed++;
        cycle();
        checks++;
        if ({valid, pend} !== {1'b0, 16'h0000})
            $display("FAIL prio_end: valid=%b pend=%h want 0 0000",
                     valid, pend);
        else passed++;
        ack = 1'b0;
    endtask

    task automatic test_hold_stable();
        do_reset();
        d = 16'h0008; en = 1'b1;
        cycle();
        d = '0; en = 1'b0;
        cycle();
        d = 16'h8000; en = 1'b1;
        cycle();
        d = '0; en = 1'b0;
        checks++;
        if ({valid, a, pend} !== {1'b1, 4'd3, 16'h8008})
            $display("FAIL hold_stable: valid=%b a=%0d pend=%h want 1 3 8008",
                     valid, a, pend);
        else passed++;
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        checks++;
        if ({valid, a, pend} !== {1'b1, 4'd15, 16'h8000})
            $display("FAIL hold_next: valid=%b a=%0d pend=%h want 1 15 8000",
                     valid, a, pend);
        else passed++;
    endtask

    task automatic test_set_clear();
        do_reset();
        d = 16'h0020; en = 1'b1;
        cycle();
        d = '0; en = 1'b0;
        cycle();
        d = 16'h0020; en = 1'b1; ack = 1'b1;
        cycle();
        d = '0; en = 1'b0;
        checks++;
        if ({valid, a, pend} !== {1'b1, 4'd5, 16'h0020})
            $display("FAIL set_wins: valid=%b a=%0d pend=%h want 1 5 0020",
                     valid, a, pend);
        else passed++;
        cycle();
        ack = 1'b0;
        checks++;
        if ({valid, pend} !== {1'b0, 16'h0000})
            $display("FAIL set_clear_end: valid=%b pend=%h want 0 0000",
                     valid, pend);
        else passed++;
    endtask

    task automatic test_en_reset();
        do_reset();
        en = 1'b0; d = 16'hFFFF;
        repeat (3) cycle();
        checks++;
        if ({valid, pend} !== {1'b0, 16'h0000})
            $display("FAIL en_gate: valid=%b pend=%h want 0 0000", valid, pend);
        else passed++;
        d = 16'h0002; en = 1'b1;
        cycle();
        d = '0; en = 1'b0;
        cycle();
        reset = 1'b1; en = 1'b1; d = 16'hFFFF; ack = 1'b1;
        cycle();
        checks++;
        if ({valid, a, pend} !== {1'b0, 4'd0, 16'h0000})
            $display("FAIL mid_reset: valid=%b a=%0d pend=%h want 0 0 0000",
                     valid, a, pend);
        else passed++;
        reset = 1'b0; d = 16'h0004; en = 1'b1; ack = 1'b0;
        cycle();
        d = '0; en = 1'b0;
        cycle();
        checks++;
        if ({valid, a} !== {1'b1, 4'd2})
            $display("FAIL post_reset_sel: valid=%b a=%0d want 1 2", valid, a);
        else passed++;
    endtask

`ifdef SEQ_ENCODER_RR_EN
    task automatic test_rr();
        do_reset();
        d = 16'h8004; en = 1'b1;
        cycle();
        ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if ({valid, a} !== {1'b1, (i % 2 == 0) ? 4'd15 : 4'd2})
                $display("FAIL rr_step%0d: valid=%b a=%0d want 1 %0d",
                         i, valid, a, (i % 2 == 0) ? 15 : 2);
            else passed++;
        end
        ack = 1'b0; d = '0; en = 1'b0;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            en    = ($urandom_range(0, 3) != 0);
            d     = N'($urandom & $urandom & $urandom);
            ack   = $urandom_range(0, 1) == 1;
            cycle();
            checks++;
            if ({valid, a, pend} !== {m_busy, W'(m_idx), m_pend})
                $display("FAIL rand_%0d: valid=%b a=%0d pend=%h want %b %0d %h",
                         i, valid, a, pend, m_busy, m_idx, m_pend);
            else passed++;
            checks++;
            if (valid && !pend[a])
                $display("FAIL rand_live_%0d: a=%0d pend=%h not pending",
                         i, a, pend);
            else passed++;
        end
        reset = 1'b0; en = 1'b0; d = '0; ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_hold_stable();
        test_set_clear();
        test_en_reset();
`ifdef SEQ_ENCODER_RR_EN
        test_rr();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
